// File: rtl/wave_monitor.sv
// Measures one waveform cycle (period, min, max) from a strobed sample stream; done one cycle after the closing crossing.
// No back-pressure: accepts one sample per clk, ignores start while busy, outputs held until the next done.
module wave_monitor #(
  parameter int SAMPLE_W = 8,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] threshold,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic [PERIOD_W-1:0] period_out,
  output logic [SAMPLE_W-1:0] min_out,
  output logic [SAMPLE_W-1:0] max_out
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

  state_t              state, state_nxt;
  logic [SAMPLE_W-1:0] thr, thr_nxt;
  logic [SAMPLE_W-1:0] prev, prev_nxt;
  logic                prev_vld, prev_vld_nxt;
  logic [PERIOD_W-1:0] cnt, cnt_nxt;
  logic [SAMPLE_W-1:0] run_min, run_min_nxt, run_max, run_max_nxt;
  logic                busy_nxt, done_nxt, timeout_nxt;
  logic [PERIOD_W-1:0] period_nxt;
  logic [SAMPLE_W-1:0] min_nxt, max_nxt;
  logic                crossing;

  assign crossing = sample_valid && prev_vld && (prev < thr) && (sample_in >= thr);

  always_comb begin
    state_nxt    = state;
    thr_nxt      = thr;
    prev_nxt     = prev;
    prev_vld_nxt = prev_vld;
    cnt_nxt      = cnt;
    run_min_nxt  = run_min;
    run_max_nxt  = run_max;
    done_nxt     = 1'b0;
    timeout_nxt  = timeout;
    period_nxt   = period_out;
    min_nxt      = min_out;
    max_nxt      = max_out;

    case (state)
      IDLE: begin
        if (start) begin
          thr_nxt      = threshold;
          cnt_nxt      = '0;
          prev_vld_nxt = 1'b0;
          state_nxt    = ARM;
        end
      end
      ARM: begin
        if (sample_valid) begin
          prev_nxt     = sample_in;
          prev_vld_nxt = 1'b1;
          if (crossing) begin
            cnt_nxt     = CNT_ONE;
            run_min_nxt = sample_in;
            run_max_nxt = sample_in;
            state_nxt   = MEASURE;
          end else if (cnt == CNT_MAX - CNT_ONE) begin
            // This sample would be the all-ones'th without a crossing: give up.
            period_nxt  = CNT_MAX;
            timeout_nxt = 1'b1;
            min_nxt     = '0;
            max_nxt     = '0;
            done_nxt    = 1'b1;
            state_nxt   = DONE;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      MEASURE: begin
        if (sample_valid) begin
          prev_nxt     = sample_in;
          prev_vld_nxt = 1'b1;
          if (crossing) begin
            period_nxt  = cnt;
            timeout_nxt = 1'b0;
            min_nxt     = run_min;
            max_nxt     = run_max;
            done_nxt    = 1'b1;
            state_nxt   = DONE;
          end else if (cnt == CNT_MAX) begin
            period_nxt  = CNT_MAX;
            timeout_nxt = 1'b1;
            min_nxt     = run_min;
            max_nxt     = run_max;
            done_nxt    = 1'b1;
            state_nxt   = DONE;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
            if (sample_in < run_min) run_min_nxt = sample_in;
            if (sample_in > run_max) run_max_nxt = sample_in;
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == ARM) || (state_nxt == MEASURE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      thr        <= '0;
      prev       <= '0;
      prev_vld   <= 1'b0;
      cnt        <= '0;
      run_min    <= '0;
      run_max    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      period_out <= '0;
      min_out    <= '0;
      max_out    <= '0;
    end else begin
      state      <= state_nxt;
      thr        <= thr_nxt;
      prev       <= prev_nxt;
      prev_vld   <= prev_vld_nxt;
      cnt        <= cnt_nxt;
      run_min    <= run_min_nxt;
      run_max    <= run_max_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      timeout    <= timeout_nxt;
      period_out <= period_nxt;
      min_out    <= min_nxt;
      max_out    <= max_nxt;
    end
  end

endmodule

// File: tb/tb_wave_monitor.sv
// Directed bench for wave_monitor: a 16-bit-period instance and an 8-bit-period
// instance share the sample stream; each has its own start.
module tb_wave_monitor;

  localparam int SAW = 0, SQR = 1, EDGE = 2, CONST = 3;

  typedef struct {
    int         pat;
    int         gap;
    logic [7:0] thr;
    bit         use8;
    int         exp_n;
    int         exp_per;
    int         exp_min;
    int         exp_max;
    bit         exp_to;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, sample_valid, start, start8;
  logic [7:0]  sample_in, threshold;
  logic        busy, done, timeout;
  logic [15:0] period_out;
  logic [7:0]  min_out, max_out;
  logic        busy8, done8, timeout8;
  logic [7:0]  period8, min8, max8;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  vec_t vecs[8];

  always #5 clk = ~clk;

  wave_monitor dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .threshold(threshold), .start(start), .busy(busy), .done(done),
    .timeout(timeout), .period_out(period_out), .min_out(min_out), .max_out(max_out)
  );

  wave_monitor #(.SAMPLE_W(8), .PERIOD_W(8)) dut8 (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .threshold(threshold), .start(start8), .busy(busy8), .done(done8),
    .timeout(timeout8), .period_out(period8), .min_out(min8), .max_out(max8)
  );

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic logic [7:0] samp(input int pat, input int k);
    case (pat)
      SAW:     return 8'((k % 10) * 25);
      SQR:     return ((k % 16) < 8) ? 8'd230 : 8'd20;
      EDGE:    return ((k % 2) == 0) ? 8'd99 : 8'd100;
      default: return 8'd50;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // A junk sample of 0 rides along with start; it must not become prev.
  task automatic pulse_start(input bit use8, input logic [7:0] thr, input string tag);
    threshold    = thr;
    sample_valid = 1'b1;
    sample_in    = 8'd0;
    if (use8) start8 = 1'b1; else start = 1'b1;
    tick;
    start = 1'b0; start8 = 1'b0; sample_valid = 1'b0;
    check({tag, " busy_after_start"}, use8 ? busy8 : busy, 1);
  endtask

  task automatic feed(input int pat, input int gap, input bit use8, input int budget,
                      input int mid_start, output int nsamp, output bit got);
    int cyc;
    cyc = 0; nsamp = 0; got = 1'b0;
    while (!got && cyc < budget) begin
      sample_valid = ((cyc % gap) == 0);
      if (sample_valid) begin
        sample_in = samp(pat, nsamp);
        nsamp++;
      end
      start = (mid_start >= 0) && sample_valid && (nsamp == mid_start);
      tick;
      start = 1'b0; sample_valid = 1'b0;
      cyc++;
      got = use8 ? done8 : done;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    bit got;
    logic [31:0] per;
    pulse_start(v.use8, v.thr, tag);
    feed(v.pat, v.gap, v.use8, 1000, -1, n, got);
    check({tag, " done_seen"}, got, 1);
    check({tag, " samples_to_done"}, n, v.exp_n);
    per = v.use8 ? 32'(period8) : 32'(period_out);
    check({tag, " period"}, per, v.exp_per);
    check({tag, " min"}, v.use8 ? min8 : min_out, v.exp_min);
    check({tag, " max"}, v.use8 ? max8 : max_out, v.exp_max);
    check({tag, " timeout"}, v.use8 ? timeout8 : timeout, v.exp_to);
    check({tag, " busy_in_done"}, v.use8 ? busy8 : busy, 0);
    tick;
    check({tag, " done_one_cycle"}, v.use8 ? done8 : done, 0);
    check({tag, " period_held"}, v.use8 ? 32'(period8) : 32'(period_out), v.exp_per);
  endtask

  initial begin
    int n;
    bit got;
    int d0;

    vecs[0] = '{SAW,   1, 8'd100, 1'b0, 15,  10,  0, 225, 1'b0};
    vecs[1] = '{SQR,   3, 8'd128, 1'b0, 33,  16, 20, 230, 1'b0};
    vecs[2] = '{SAW,   2, 8'd100, 1'b0, 15,  10,  0, 225, 1'b0};
    vecs[3] = '{EDGE,  1, 8'd100, 1'b0,  4,   2, 99, 100, 1'b0};
    vecs[4] = '{SAW,   1, 8'd200, 1'b0, 19,  10,  0, 225, 1'b0};
    vecs[5] = '{CONST, 1, 8'd100, 1'b1, 255, 255, 0,   0, 1'b1};
    vecs[6] = '{SAW,   1, 8'd100, 1'b1, 15,  10,  0, 225, 1'b0};
    vecs[7] = '{SQR,   1, 8'd128, 1'b1, 33,  16, 20, 230, 1'b0};

    rst = 1'b1; start = 1'b0; start8 = 1'b0; sample_valid = 1'b0;
    sample_in = 8'd0; threshold = 8'd0;
    tick; tick;
    rst = 1'b0;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset timeout", timeout, 0);
    check("reset period", period_out, 0);
    check("reset min", min_out, 0);
    check("reset max", max_out, 0);
    check("reset busy8", busy8, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while in MEASURE (crossing at sample 4, stop after 8).
    pulse_start(1'b0, 8'd100, "rstmid");
    feed(SAW, 1, 1'b0, 8, -1, n, got);
    check("rstmid no_done_yet", got, 0);
    check("rstmid busy_before", busy, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rstmid busy", busy, 0);
    check("rstmid done", done, 0);
    check("rstmid timeout", timeout, 0);
    check("rstmid period", period_out, 0);
    check("rstmid min", min_out, 0);
    check("rstmid max", max_out, 0);
    run_vec(vecs[0], "after_rst");

    // Start mid-MEASURE and in the DONE cycle are both ignored.
    d0 = done_cnt;
    pulse_start(1'b0, 8'd100, "busystart");
    feed(SAW, 1, 1'b0, 100, 8, n, got);
    check("busystart done_seen", got, 1);
    check("busystart samples", n, 15);
    check("busystart period", period_out, 10);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("busystart done_cycle_start_ignored", busy, 0);
    for (int k = 0; k < 25; k++) begin
      sample_valid = 1'b1;
      sample_in = samp(SAW, k);
      tick;
    end
    sample_valid = 1'b0;
    check("busystart still_idle", busy, 0);
    check("busystart one_done_pulse", done_cnt - d0, 1);
    d0 = done_cnt;
    run_vec(vecs[0], "restart");
    check("restart one_more_done", done_cnt - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wave_monitor.md
# wave_monitor

Capture-side measurement block for the multifunctional wave generator. It consumes the generator's 8-bit sample stream, together with a sample strobe, and measures one full cycle of the waveform: period in samples, minimum and maximum. Results are held on the outputs for the bring-up logic and the loopback self-test to read. It is the receiving end of the generator's sample interface.

## Interface

Parameters:
- SAMPLE_W, 8, sample width in bits.
- PERIOD_W, 16, width of the period counter and of period_out.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- sample_in  in  SAMPLE_W  unsigned sample from the wave generator.
- sample_valid  in  1  sample_in is valid this cycle. Gaps are allowed.
- threshold  in  SAMPLE_W  crossing level, sampled on start.
- start  in  1  one-cycle request to begin a measurement.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when results update.
- timeout  out  1  high while the held results come from a timed-out measurement.
- period_out  out  PERIOD_W  samples per cycle.
- min_out  out  SAMPLE_W  minimum sample over the measured cycle.
- max_out  out  SAMPLE_W  maximum sample over the measured cycle.

## Operation

- Rising crossing: a valid sample with prev < thr and cur >= thr.
  - prev is the most recent valid sample accepted in ARM or MEASURE.
  - thr is the threshold captured on start.
  - The first valid sample after start has no prev, so it is never a crossing.
- FSM states: IDLE, ARM, MEASURE, DONE.
- IDLE:
  - busy=0.
  - start=1 → capture threshold, clear cnt, invalidate prev, go to ARM.
- ARM:
  - Each valid sample increments cnt.
  - Crossing → set cnt=1, min=max=sample, go to MEASURE.
  - If cnt==2^PERIOD_W-1 on a non-crossing valid sample → timeout path.
- MEASURE: each valid sample is checked as follows.
  - Crossing → period=cnt, go to DONE. The second crossing sample is excluded from min/max.
  - Otherwise → cnt+=1 and update min/max.
  - If cnt==2^PERIOD_W-1 before the increment → timeout path.
- Timeout path:
  - period_out=all ones and timeout=1.
  - From ARM: min_out=max_out=0.
  - From MEASURE: min_out/max_out hold the running values.
  - Go to DONE.
- DONE:
  - done=1 for exactly one cycle, results loaded, busy=0, go to IDLE.
- Outputs hold their values until the next DONE.
- timeout clears at the next DONE that is not a timeout.
- start while busy is ignored, including a start in the DONE cycle.
- sample_valid=0 cycles are invisible: they change neither cnt nor prev.
- Comparisons are unsigned. The counter saturates by the timeout rule and never wraps.

## Timing

- Reset values:
  - busy=0, done=0, timeout=0.
  - period_out=0, min_out=0, max_out=0.
  - state=IDLE.
- rst overrides everything, including mid-measurement. Any partial measurement is discarded.
- Start to arm: start in cycle t → busy=1 in cycle t+1. A sample valid in cycle t is ignored.
- Completion latency: second crossing sample valid in cycle t → done=1 in cycle t+1.
  - Results are valid in that same cycle t+1 and held afterwards.
- No combinational path from any input to any output. All outputs are registered.
- Throughput: one sample per clk with no back-pressure. There is no ready signal.

## Test plan

- Sawtooth: samples k*25, k=0..9 repeating, sample_valid=1 every cycle, threshold=100.
  - Required: done after the second 75→100 step, period_out=10, min_out=0, max_out=225, timeout=0.
- Square wave: 8 samples of 230 then 8 of 20, sample_valid every 3rd cycle, threshold=128.
  - Required: period_out=16, min_out=20, max_out=230.
  - Sample gaps must not change the result.
- Constant 50 with PERIOD_W=8, start once.
  - Required: done+timeout on the cycle after the 255th valid sample, period_out=255, min_out=max_out=0.
- Reset mid-measurement: assert rst for 1 cycle while in MEASURE, then run the sawtooth case again.
  - Required: all outputs 0 immediately after reset.
  - The following measurement yields period_out=10.
- Start while busy: pulse start again mid-MEASURE on the sawtooth.
  - Required: exactly one done pulse and period_out=10.
  - A new start after done re-measures, and done pulses again.
- Exact-threshold edge: samples 99,100,99,100,… with threshold=100.
  - Required: period_out=2, min_out=99, max_out=100.
